neuron_mac_sigmoid: RTL and testbench

// - Sigmoid ALU consumed by the network controller. Takes 4 weight/input pairs plus a

---
 rtl/neuron_mac_sigmoid_if.sv | 31 +++
 rtl/neuron_mac_sigmoid.sv | 147 ++++++++++++++
 tb/tb_neuron_mac_sigmoid.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_sigmoid_if.sv
// Operand/result bundle between the network controller and the sigmoid ALU.
// The controller drives weights, inputs, bias and strobes; the ALU returns the activation.
interface neuron_mac_sigmoid_if;
    logic [3:0] weight1;
    logic [3:0] weight2;
    logic [3:0] weight3;
    logic [3:0] weight4;
    logic [3:0] input1;
    logic [3:0] input2;
    logic [3:0] input3;
    logic [3:0] input4;
    logic [3:0] bias;
    logic       clear;
    logic       accumulate;
    logic [3:0] ALUOutput;
    logic       acc_sat;

    modport master (
        output weight1, weight2, weight3, weight4,
        output input1, input2, input3, input4,
        output bias, clear, accumulate,
        input  ALUOutput, acc_sat
    );

    modport slave (
        input  weight1, weight2, weight3, weight4,
        input  input1, input2, input3, input4,
        input  bias, clear, accumulate,
        output ALUOutput, acc_sat
    );
endinterface

// File: rtl/neuron_mac_sigmoid.sv
// Neuron ALU: 4-way Q1.2 x Q0.4 multiply, pipelined sum, saturating accumulator
// and a registered piecewise-linear sigmoid of (acc + bias).
module neuron_mac_sigmoid #(
    parameter int ACC_W     = 16,
    parameter int SIG_SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    neuron_mac_sigmoid_if.slave  bus
);

    localparam int PROD_W = 9;
    localparam int SUM_W  = 11;
    localparam int PRE_W  = ACC_W + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX_C = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN_C = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [PRE_W-1:0] SIG_LO_C  = PRE_W'(-8);
    localparam logic signed [PRE_W-1:0] SIG_HI_C  = PRE_W'(7);
    localparam logic signed [PRE_W-1:0] SIG_MID_C = PRE_W'(8);

    // Signed Q1.2 weight times unsigned Q0.4 input; the 9-bit result never wraps.
    function automatic logic signed [PROD_W-1:0] mul_wx(input logic [3:0] w, input logic [3:0] x);
        logic signed [PROD_W-1:0] a;
        logic signed [PROD_W-1:0] b;
        a = {{(PROD_W-4){w[3]}}, w};
        b = {{(PROD_W-4){1'b0}}, x};
        return a * b;
    endfunction

    function automatic logic signed [SUM_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
        return {{(SUM_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // One guard bit above the accumulator: its MSB is the true sign of the sum.
    function automatic logic signed [ACC_W:0] wide_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [SUM_W-1:0] s);
        logic signed [ACC_W:0] a_ext;
        logic signed [ACC_W:0] s_ext;
        a_ext = {a[ACC_W-1], a};
        s_ext = {{(ACC_W+1-SUM_W){s[SUM_W-1]}}, s};
        return a_ext + s_ext;
    endfunction

    // 0.5 + x/4 in Q0.4; the arithmetic shift floors toward -inf before clamping.
    function automatic logic [3:0] sigmoid(input logic signed [PRE_W-1:0] pre);
        logic signed [PRE_W-1:0] sh;
        logic signed [PRE_W-1:0] off;
        sh  = pre >>> SIG_SHIFT;
        off = sh + SIG_MID_C;
        if (sh < SIG_LO_C) begin
            return 4'd0;
        end else if (sh > SIG_HI_C) begin
            return 4'd15;
        end else begin
            return off[3:0];
        end
    endfunction

    logic [3:0]               w_s [4];
    logic [3:0]               x_s [4];
    logic signed [PROD_W-1:0] prod_d [4];
    logic signed [PROD_W-1:0] prod_q [4];
    logic signed [SUM_W-1:0]  sum_d;
    logic signed [SUM_W-1:0]  sum_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     acc_sat_d;
    logic                     acc_sat_q;
    logic [3:0]               alu_d;
    logic [3:0]               alu_q;
    logic signed [ACC_W:0]    acc_wide_s;
    logic signed [PRE_W-1:0]  bias_ext_s;
    logic signed [PRE_W-1:0]  pre_s;

    assign w_s[0] = bus.weight1;
    assign w_s[1] = bus.weight2;
    assign w_s[2] = bus.weight3;
    assign w_s[3] = bus.weight4;
    assign x_s[0] = bus.input1;
    assign x_s[1] = bus.input2;
    assign x_s[2] = bus.input3;
    assign x_s[3] = bus.input4;

    // Stage 1 products and stage 2 sum of the registered products.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            prod_d[i] = mul_wx(w_s[i], x_s[i]);
        end
        sum_d = sext_prod(prod_q[0]) + sext_prod(prod_q[1])
              + sext_prod(prod_q[2]) + sext_prod(prod_q[3]);
    end

    // Accumulator with clear priority and clamp-on-overflow.
    always_comb begin
        acc_d      = acc_q;
        acc_sat_d  = acc_sat_q;
        acc_wide_s = wide_add(acc_q, sum_q);
        if (bus.clear) begin
            acc_d     = '0;
            acc_sat_d = 1'b0;
        end else if (bus.accumulate) begin
            if (acc_wide_s[ACC_W] != acc_wide_s[ACC_W-1]) begin
                acc_d     = acc_wide_s[ACC_W] ? ACC_MIN_C : ACC_MAX_C;
                acc_sat_d = 1'b1;
            end else begin
                acc_d     = acc_wide_s[ACC_W-1:0];
                acc_sat_d = acc_sat_q;
            end
        end else begin
            acc_d     = acc_q;
            acc_sat_d = acc_sat_q;
        end
    end

    // Bias stays outside the accumulator; align Q1.2 to the Q.6 accumulator grid.
    always_comb begin
        bias_ext_s = {{(PRE_W-8){bus.bias[3]}}, bus.bias, 4'b0000};
        pre_s      = {acc_q[ACC_W-1], acc_q} + bias_ext_s;
        alu_d      = sigmoid(pre_s);
    end

    // Pipeline, accumulator and activation registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 4; i++) begin
                prod_q[i] <= '0;
            end
            sum_q     <= '0;
            acc_q     <= '0;
            acc_sat_q <= 1'b0;
            alu_q     <= 4'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                prod_q[i] <= prod_d[i];
            end
            sum_q     <= sum_d;
            acc_q     <= acc_d;
            acc_sat_q <= acc_sat_d;
            alu_q     <= alu_d;
        end
    end

    assign bus.ALUOutput = alu_q;
    assign bus.acc_sat   = acc_sat_q;

endmodule

// File: tb/tb_neuron_mac_sigmoid.sv
// Directed bench for neuron_mac_sigmoid: an integer model of the accumulator and
// sigmoid feeds a scoreboard queue that is drained against the DUT outputs.
module tb_neuron_mac_sigmoid;

    logic clk;
    logic n_rst;

    neuron_mac_sigmoid_if bus ();

    neuron_mac_sigmoid dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] alu;
        logic       sat;
        int         acc;
    } exp_t;

    exp_t sb_q[$];
    int   vectors_applied = 0;
    int   miscompares     = 0;
    int   model_acc       = 0;
    int   model_sat       = 0;
    int   model_bias      = 0;
    int   cur_w           = 0;
    int   cur_x           = 0;

    function automatic int s4(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    // Real-valued w*x scaled to Q.6: weight/4 * input/16 * 64 = w*x.
    function automatic int model_sum(input int w, input int x);
        return 4 * (s4(w) * x);
    endfunction

    function automatic int model_sig(input int acc, input int b);
        int pre;
        int q;
        pre = acc + b * 16;
        if (pre >= 0) q = pre / 16;
        else          q = -((-pre + 15) / 16);
        q = q + 8;
        if (q < 0)  q = 0;
        if (q > 15) q = 15;
        return q;
    endfunction

    function automatic void model_add(input int s);
        model_acc = model_acc + s;
        if (model_acc > 32767) begin
            model_acc = 32767;
            model_sat = 1;
        end else if (model_acc < -32768) begin
            model_acc = -32768;
            model_sat = 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_raw(input string tag, input int alu, input int sat, input int acc);
        exp_t e;
        e.tag = tag;
        e.alu = alu[3:0];
        e.sat = sat[0];
        e.acc = acc;
        sb_q.push_back(e);
    endtask

    task automatic push_model(input string tag);
        push_raw(tag, model_sig(model_acc, model_bias), model_sat, model_acc);
    endtask

    task automatic check_out();
        exp_t e;
        int   acc_obs;
        if (sb_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e       = sb_q.pop_front();
        acc_obs = int'(dut.acc_q);
        vectors_applied++;
        assert (bus.ALUOutput === e.alu) else begin
            miscompares++;
            $error("FAIL %s.alu observed=%0d expected=%0d", e.tag, bus.ALUOutput, e.alu);
        end
        vectors_applied++;
        assert (bus.acc_sat === e.sat) else begin
            miscompares++;
            $error("FAIL %s.sat observed=%0d expected=%0d", e.tag, bus.acc_sat, e.sat);
        end
        vectors_applied++;
        assert (acc_obs == e.acc) else begin
            miscompares++;
            $error("FAIL %s.acc observed=%0d expected=%0d", e.tag, acc_obs, e.acc);
        end
    endtask

    // Drive operands, then let the two pipeline stages settle.
    task automatic set_ops(input int w, input int x, input int b);
        bus.weight1 = w[3:0]; bus.weight2 = w[3:0];
        bus.weight3 = w[3:0]; bus.weight4 = w[3:0];
        bus.input1  = x[3:0]; bus.input2  = x[3:0];
        bus.input3  = x[3:0]; bus.input4  = x[3:0];
        bus.bias    = b[3:0];
        cur_w       = w;
        cur_x       = x;
        model_bias  = s4(b);
        tick();
        tick();
    endtask

    task automatic clr();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        model_acc = 0;
        model_sat = 0;
    endtask

    task automatic accum(input int n);
        bus.accumulate = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            model_add(model_sum(cur_w, cur_x));
        end
        bus.accumulate = 1'b0;
    endtask

    task automatic set_bias(input int b);
        bus.bias   = b[3:0];
        model_bias = s4(b);
    endtask

    initial begin
        // Reset with random operands and strobes that must be ignored
        n_rst          = 1'b0;
        bus.weight1    = 4'($urandom); bus.weight2 = 4'($urandom);
        bus.weight3    = 4'($urandom); bus.weight4 = 4'($urandom);
        bus.input1     = 4'($urandom); bus.input2  = 4'($urandom);
        bus.input3     = 4'($urandom); bus.input4  = 4'($urandom);
        bus.bias       = 4'($urandom);
        bus.clear      = 1'b1;
        bus.accumulate = 1'b1;
        tick();
        tick();
        tick();
        push_raw("reset", 0, 0, 0);
        check_out();

        bus.clear      = 1'b0;
        bus.accumulate = 1'b0;
        set_bias(0);
        n_rst = 1'b1;
        tick();
        tick();
        push_model("release");
        check_out();

        // Positive MAC: four products of 16 -> 64 -> 12
        set_ops(4'h4, 4'h4, 4'h0);
        clr();
        tick();
        accum(1);
        tick();
        push_raw("pos_mac", 12, 0, 64);
        check_out();

        // Negative: clamps the activation to 0 without saturating acc
        set_ops(4'hC, 4'h8, 4'h0);
        clr();
        accum(2);
        tick();
        push_raw("neg_clamp", 0, 0, -256);
        check_out();

        // Bias only, bias changing together with clear
        bus.clear = 1'b1;
        set_bias(4'h2);
        tick();
        bus.clear = 1'b0;
        model_acc = 0;
        model_sat = 0;
        tick();
        push_raw("bias_p2", 10, 0, 0);
        check_out();
        set_bias(4'hE);
        tick();
        push_raw("bias_m2", 6, 0, 0);
        check_out();
        set_bias(4'h7);
        tick();
        push_raw("bias_p7", 15, 0, 0);
        check_out();
        set_bias(4'h0);

        // Floor behaviour: acc=-4 gives 7, not 8
        set_ops(4'hF, 4'h1, 4'h0);
        clr();
        accum(1);
        tick();
        push_raw("floor", 7, 0, -4);
        check_out();

        // Negative saturation and sticky flag, then clear
        set_ops(4'h8, 4'hF, 4'h0);
        clr();
        accum(70);
        tick();
        push_raw("sat_neg", 0, 1, -32768);
        check_out();
        accum(1);
        tick();
        push_model("sat_hold");
        check_out();
        clr();
        tick();
        push_raw("sat_clear", 8, 0, 0);
        check_out();

        // Early accumulate sees the stale sum
        set_ops(4'h4, 4'h4, 4'h0);
        clr();
        bus.weight1 = 4'h4; bus.weight2 = 4'h4; bus.weight3 = 4'h4; bus.weight4 = 4'h4;
        bus.input1  = 4'h8; bus.input2  = 4'h8; bus.input3  = 4'h8; bus.input4  = 4'h8;
        cur_x = 8;
        bus.accumulate = 1'b1;
        tick();
        bus.accumulate = 1'b0;
        model_add(64);
        tick();
        push_raw("stale_sum", 12, 0, 64);
        check_out();
        tick();
        accum(1);
        tick();
        push_raw("new_sum", 15, 0, 192);
        check_out();

        // Clear beats a simultaneous accumulate
        bus.clear      = 1'b1;
        bus.accumulate = 1'b1;
        tick();
        bus.clear      = 1'b0;
        bus.accumulate = 1'b0;
        model_acc = 0;
        model_sat = 0;
        tick();
        push_model("clr_prio");
        check_out();

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
